// File: rtl/strb_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : strb_mem_pkg
// Description : Shared constants and helpers for the byte-strobed memory:
//               byte-lane / offset derivation and access legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package strb_mem_pkg;

  // Constants for the default 32-bit word configuration.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = DEF_DATA_WIDTH / 8;
  localparam int OFFSET_BITS    = $clog2(STRB_WIDTH);

  // Number of byte lanes in a word of the given width.
  function automatic int calc_strb_width(input int dw);
    return dw / 8;
  endfunction

  // Number of low byte-address bits that select a byte within a word.
  function automatic int calc_offset_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

  // An access is legal when word-aligned and its word index is below depth.
  function automatic logic addr_ok(input logic [63:0] addr,
                                   input int          offset_bits,
                                   input int          depth);
    logic [63:0] mask;
    mask = (64'd1 << offset_bits) - 64'd1;
    return ((addr & mask) == 64'd0) && ((addr >> offset_bits) < 64'(depth));
  endfunction

endpackage : strb_mem_pkg
`default_nettype wire

// File: rtl/strb_merge.sv
`default_nettype none
// ============================================================================
// Module      : strb_merge
// Description : Byte-lane merge; each byte of the result comes from the new
//               word where its strobe bit is set, else from the old word.
// Revision    : 1.0 - initial release
// ============================================================================
module strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_new,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  output logic [DATA_WIDTH-1:0]   o_merged
);

  for (genvar g = 0; g < DATA_WIDTH / 8; g++) begin : g_lane
    assign o_merged[8*g +: 8] = i_strb[g] ? i_new[8*g +: 8] : i_old[8*g +: 8];
  end

endmodule : strb_merge
`default_nettype wire

// File: rtl/strb_mem.sv
`default_nettype none
// ============================================================================
// Module      : strb_mem
// Description : Register-based word memory with byte-strobed writes, a 1- or
//               2-stage read pipeline, alignment/range error reporting and a
//               configurable same-word read/write collision policy.
// Revision    : 1.0 - initial release
// ============================================================================
module strb_mem
  import strb_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    WEN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  output logic                    WERR,
  input  logic                    REN,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    RVALID,
  output logic                    RERR
);

  localparam int c_STRB_W   = calc_strb_width(DATA_WIDTH);
  localparam int c_OFF_BITS = calc_offset_bits(DATA_WIDTH);
  localparam int c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Parameter legality; the lane count must be a power of two so that the
  // address shift by the offset width lands exactly on word boundaries.
  if ((DATA_WIDTH < 8) || (DATA_WIDTH > 128) || ((DATA_WIDTH % 8) != 0) ||
      ((c_STRB_W & (c_STRB_W - 1)) != 0)) begin : g_bad_data_width
    $error("strb_mem: DATA_WIDTH must be 8, 16, 32, 64 or 128");
  end
  if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 62)) begin : g_bad_addr_width
    $error("strb_mem: ADDR_WIDTH must be in 1..62");
  end
  if ((DEPTH < 1) ||
      ((64'(DEPTH) * 64'(c_STRB_W)) > (64'd1 << ADDR_WIDTH))) begin : g_bad_depth
    $error("strb_mem: DEPTH*DATA_WIDTH/8 must fit in the byte address space");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("strb_mem: READ_LATENCY must be 1 or 2");
  end
  if ((WRITE_FIRST != 0) && (WRITE_FIRST != 1)) begin : g_bad_write_first
    $error("strb_mem: WRITE_FIRST must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_wr_legal;
  logic                  w_wr_ok;
  logic [c_IDX_W-1:0]    w_widx;
  logic [DATA_WIDTH-1:0] w_wr_merged;

  logic                  w_rd_legal;
  logic                  w_rd_ok;
  logic [c_IDX_W-1:0]    w_ridx;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_rd_bypass;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic                  r_werr;
  logic                  r_s1_valid;
  logic                  r_s1_err;
  logic [DATA_WIDTH-1:0] r_s1_data;

  // Address decode for both ports.
  assign w_wr_legal = addr_ok(64'(AWADDR), c_OFF_BITS, DEPTH);
  assign w_rd_legal = addr_ok(64'(ARADDR), c_OFF_BITS, DEPTH);
  assign w_widx     = c_IDX_W'(AWADDR >> c_OFF_BITS);
  assign w_ridx     = c_IDX_W'(ARADDR >> c_OFF_BITS);
  assign w_wr_ok    = WEN && w_wr_legal;
  assign w_rd_ok    = REN && w_rd_legal;

  strb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_merge (
    .i_old    (r_mem[w_widx]),
    .i_new    (WDATA),
    .i_strb   (WSTRB),
    .o_merged (w_wr_merged)
  );

  // Collision bypass: the word being read, as it will look after this write.
  assign w_rd_old = r_mem[w_ridx];

  strb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_bypass (
    .i_old    (w_rd_old),
    .i_new    (WDATA),
    .i_strb   (WSTRB),
    .o_merged (w_rd_bypass)
  );

  assign w_collide = w_wr_ok && w_rd_ok && (w_widx == w_ridx);

  // Word captured at the read sampling edge; erroneous reads return zero.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_ok) begin
      w_rd_word = (w_collide && (WRITE_FIRST == 1)) ? w_rd_bypass : w_rd_old;
    end
  end

  // Storage: cleared on reset, otherwise strobe-merged on a legal write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[w_widx] <= w_wr_merged;
    end
  end

  // Write error pulse for misaligned or out-of-range write requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_werr <= 1'b0;
    end else begin
      r_werr <= WEN && !w_wr_legal;
    end
  end

  // First read stage: data and status sampled alongside the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= REN;
      r_s1_err   <= REN && !w_rd_legal;
      r_s1_data  <= w_rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_s2_valid;
    logic                  r_s2_err;
    logic [DATA_WIDTH-1:0] r_s2_data;

    // Second read stage: holds the already-sampled word, immune to writes.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s2_valid <= 1'b0;
        r_s2_err   <= 1'b0;
        r_s2_data  <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        r_s2_err   <= r_s1_err;
        r_s2_data  <= r_s1_data;
      end
    end

    assign RVALID = r_s2_valid;
    assign RERR   = r_s2_err;
    assign RDATA  = r_s2_data;
  end else begin : g_lat1
    assign RVALID = r_s1_valid;
    assign RERR   = r_s1_err;
    assign RDATA  = r_s1_data;
  end

  assign WERR = r_werr;

endmodule : strb_mem
`default_nettype wire

// File: tb/tb_strb_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_strb_mem
// Description : Directed self-checking bench. Instance A: READ_LATENCY=1,
//               WRITE_FIRST=1. Instance B: READ_LATENCY=2, WRITE_FIRST=0.
//               Both share inputs; each is checked at its own latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strb_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [7:0]  awaddr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ren;
  logic [7:0]  araddr;

  logic        a_werr, a_rvalid, a_rerr;
  logic [31:0] a_rdata;
  logic        b_werr, b_rvalid, b_rerr;
  logic [31:0] b_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  strb_mem #(
    .DATA_WIDTH (32), .ADDR_WIDTH (8), .DEPTH (32),
    .READ_LATENCY (1), .WRITE_FIRST (1)
  ) u_dut_a (
    .clk (clk), .reset (reset),
    .WEN (wen), .AWADDR (awaddr), .WSTRB (wstrb), .WDATA (wdata), .WERR (a_werr),
    .REN (ren), .ARADDR (araddr), .RDATA (a_rdata), .RVALID (a_rvalid), .RERR (a_rerr)
  );

  strb_mem #(
    .DATA_WIDTH (32), .ADDR_WIDTH (8), .DEPTH (32),
    .READ_LATENCY (2), .WRITE_FIRST (0)
  ) u_dut_b (
    .clk (clk), .reset (reset),
    .WEN (wen), .AWADDR (awaddr), .WSTRB (wstrb), .WDATA (wdata), .WERR (b_werr),
    .REN (ren), .ARADDR (araddr), .RDATA (b_rdata), .RVALID (b_rvalid), .RERR (b_rerr)
  );

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single write; checks the WERR pulse of both instances after the edge.
  task automatic test_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic exp_err);
    wen = 1'b1; awaddr = a; wdata = d; wstrb = s;
    tick();
    wen = 1'b0;
    n_checks++;
    if ({a_werr, b_werr} !== {exp_err, exp_err}) begin
      n_fail++;
      $display("FAIL werr addr=%0d: got A=%b B=%b expected %b", a, a_werr, b_werr, exp_err);
    end
  endtask

  // Single read; checks {RVALID,RERR,RDATA} of each instance at its latency.
  task automatic test_read(input logic [7:0] a, input logic [31:0] exp_d,
                           input logic exp_err);
    ren = 1'b1; araddr = a;
    tick();
    ren = 1'b0;
    n_checks++;
    if ({a_rvalid, a_rerr, a_rdata} !== {1'b1, exp_err, exp_d}) begin
      n_fail++;
      $display("FAIL read_a addr=%0d: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
               a, a_rvalid, a_rerr, a_rdata, exp_err, exp_d);
    end
    tick();
    n_checks++;
    if ({a_rvalid, a_rerr, a_rdata} !== 34'd0) begin
      n_fail++;
      $display("FAIL read_a_idle addr=%0d: got v=%b e=%b d=%h expected all zero",
               a, a_rvalid, a_rerr, a_rdata);
    end
    n_checks++;
    if ({b_rvalid, b_rerr, b_rdata} !== {1'b1, exp_err, exp_d}) begin
      n_fail++;
      $display("FAIL read_b addr=%0d: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
               a, b_rvalid, b_rerr, b_rdata, exp_err, exp_d);
    end
    tick();
    n_checks++;
    if ({b_rvalid, b_rerr, b_rdata} !== 34'd0) begin
      n_fail++;
      $display("FAIL read_b_idle addr=%0d: got v=%b e=%b d=%h expected all zero",
               a, b_rvalid, b_rerr, b_rdata);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; wen = 1'b0; ren = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if ({a_werr, a_rvalid, a_rerr, a_rdata, b_werr, b_rvalid, b_rerr, b_rdata} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got A=%b%b%b/%h B=%b%b%b/%h expected all zero",
               a_werr, a_rvalid, a_rerr, a_rdata, b_werr, b_rvalid, b_rerr, b_rdata);
    end
    test_read(8'd12, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_strobe_write;
    test_write(8'd12, 32'hAABB_CCDD, 4'b1011, 1'b0);
    test_read(8'd12, 32'hAA00_CCDD, 1'b0);
  endtask

  task automatic test_errors;
    test_write(8'd128, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    tick();
    n_checks++;
    if ({a_werr, b_werr} !== 2'b00) begin
      n_fail++;
      $display("FAIL werr_pulse_width: got A=%b B=%b expected 0", a_werr, b_werr);
    end
    test_write(8'd13, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    tick();
    test_read(8'd12, 32'hAA00_CCDD, 1'b0);
    test_read(8'd128, 32'h0000_0000, 1'b1);
    test_read(8'd14, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_wstrb_zero;
    test_write(8'd12, 32'h1234_5678, 4'b0000, 1'b0);
    test_read(8'd12, 32'hAA00_CCDD, 1'b0);
  endtask

  task automatic test_collision;
    test_write(8'd12, 32'h1122_3344, 4'b1111, 1'b0);
    wen = 1'b1; awaddr = 8'd12; wdata = 32'hFFFF_FFFF; wstrb = 4'b0001;
    ren = 1'b1; araddr = 8'd12;
    tick();
    wen = 1'b0; ren = 1'b0;
    n_checks++;
    if ({a_rvalid, a_rdata} !== {1'b1, 32'h1122_33FF}) begin
      n_fail++;
      $display("FAIL collision_write_first: got v=%b d=%h expected v=1 d=112233ff",
               a_rvalid, a_rdata);
    end
    tick();
    n_checks++;
    if ({b_rvalid, b_rdata} !== {1'b1, 32'h1122_3344}) begin
      n_fail++;
      $display("FAIL collision_read_first: got v=%b d=%h expected v=1 d=11223344",
               b_rvalid, b_rdata);
    end
    tick();
    test_read(8'd12, 32'h1122_33FF, 1'b0);
  endtask

  task automatic test_diff_words;
    wen = 1'b1; awaddr = 8'd0; wdata = 32'hCAFE_F00D; wstrb = 4'b1111;
    ren = 1'b1; araddr = 8'd12;
    tick();
    wen = 1'b0; ren = 1'b0;
    n_checks++;
    if ({a_rvalid, a_rdata} !== {1'b1, 32'h1122_33FF}) begin
      n_fail++;
      $display("FAIL diff_words_a: got v=%b d=%h expected v=1 d=112233ff", a_rvalid, a_rdata);
    end
    tick();
    n_checks++;
    if ({b_rvalid, b_rdata} !== {1'b1, 32'h1122_33FF}) begin
      n_fail++;
      $display("FAIL diff_words_b: got v=%b d=%h expected v=1 d=112233ff", b_rvalid, b_rdata);
    end
    tick();
    test_read(8'd0, 32'hCAFE_F00D, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w [4];
    exp_w = '{32'hCAFE_F00D, 32'h0102_0304, 32'h0506_0708, 32'h1122_33FF};
    test_write(8'd4, 32'h0102_0304, 4'b1111, 1'b0);
    test_write(8'd8, 32'h0506_0708, 4'b1111, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ren    = (i < 4);
      araddr = 8'(4 * i);
      tick();
      n_checks++;
      if (i < 4) begin
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, exp_w[i]}) begin
          n_fail++;
          $display("FAIL b2b_a[%0d]: got v=%b e=%b d=%h expected v=1 e=0 d=%h",
                   i, a_rvalid, a_rerr, a_rdata, exp_w[i]);
        end
      end else if (a_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_a_tail[%0d]: got v=%b expected 0", i, a_rvalid);
      end
      n_checks++;
      if ((i >= 1) && (i < 5)) begin
        if ({b_rvalid, b_rerr, b_rdata} !== {2'b10, exp_w[i-1]}) begin
          n_fail++;
          $display("FAIL b2b_b[%0d]: got v=%b e=%b d=%h expected v=1 e=0 d=%h",
                   i, b_rvalid, b_rerr, b_rdata, exp_w[i-1]);
        end
      end else if (b_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_b_edge[%0d]: got v=%b expected 0", i, b_rvalid);
      end
    end
  endtask

  task automatic test_reset_flush;
    ren = 1'b1; araddr = 8'd12;
    tick();
    // Reset together with fresh write and read requests: all are dropped.
    reset = 1'b1;
    wen = 1'b1; awaddr = 8'd12; wdata = 32'h5555_5555; wstrb = 4'b1111;
    ren = 1'b1; araddr = 8'd0;
    tick();
    reset = 1'b0; wen = 1'b0; ren = 1'b0;
    n_checks++;
    if ({a_rvalid, b_rvalid, b_rdata} !== 34'd0) begin
      n_fail++;
      $display("FAIL flush_at_reset: got A.v=%b B.v=%b B.d=%h expected all zero",
               a_rvalid, b_rvalid, b_rdata);
    end
    tick();
    n_checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_after_reset: got A.v=%b B.v=%b expected 00", a_rvalid, b_rvalid);
    end
    test_read(8'd12, 32'h0000_0000, 1'b0);
    test_read(8'd0, 32'h0000_0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_strobe_write();
    test_errors();
    test_wstrb_zero();
    test_collision();
    test_diff_words();
    test_back_to_back();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1);
  end

endmodule : tb_strb_mem
`default_nettype wire
